lsu_mem_port: RTL and testbench

Multi-cycle load/store unit between the control unit's MEMORY stage and a data-memory bus with valid/ready handshake. Accepts one access per request (address, size, sign, write data), drives word-aligned bus transactions with byte strobes, and returns sign- or zero-extended load data plus a one-cycle done pulse. Flags misaligned accesses and bus timeouts instead of hanging the core.

---
 rtl/lsu_mem_port_pkg.sv | 22 ++
 rtl/lsu_mem_port_lane_align.sv | 35 +++
 rtl/lsu_mem_port.sv | 116 +++++++++++
 tb/tb_lsu_mem_port.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg: shared types and helpers for the load/store unit
package lsu_mem_port_pkg;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_RESP = 2'd2,
        DONE     = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    // Size code 11 falls through to the word rule.
    function automatic logic misaligned(input mem_size_t s, input logic [1:0] a);
        return (s == MEM_BYTE) ? 1'b0 : (s == MEM_HALF) ? a[0] : (a != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// lsu_mem_port_lane_align: store strobe/data replication and load lane extract/extend
module lsu_mem_port_lane_align
    import lsu_mem_port_pkg::*;
(
    input  mem_size_t             i_size,
    input  logic [1:0]            i_addr_lo,
    input  logic                  i_sign,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [3:0]            o_wstrb,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] w_shift;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_is_byte;
    logic                  w_is_half;

    assign w_is_byte = i_size == MEM_BYTE;
    assign w_is_half = i_size == MEM_HALF;
    assign w_shift   = i_rdata >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shift[7:0];
    assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    assign o_wstrb = w_is_byte ? (4'b0001 << i_addr_lo)
                   : w_is_half ? (i_addr_lo[1] ? 4'b1100 : 4'b0011)
                   : 4'b1111;
    assign o_wdata = w_is_byte ? {4{i_wdata[7:0]}}
                   : w_is_half ? {2{i_wdata[15:0]}}
                   : i_wdata;
    assign o_rdata = w_is_byte ? {{24{i_sign & w_byte[7]}}, w_byte}
                   : w_is_half ? {{16{i_sign & w_half[15]}}, w_half}
                   : i_rdata;
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: multi-cycle load/store unit bridging the MEMORY stage to a valid/ready data bus
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_wstrb,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);
    lsu_state_t            r_state, w_next;
    logic [7:0]            r_cnt;
    logic                  r_we, r_sign, r_err;
    mem_size_t             r_size, w_size;
    logic [1:0]            r_addr_lo, w_addr_lo;
    logic [DATA_WIDTH-1:0] r_rdata, r_bus_addr, r_bus_wdata, w_st_data, w_ld_data;
    logic [3:0]            r_bus_wstrb, w_st_strb;
    logic                  w_err, w_misal, w_timeout;

    // In IDLE the aligner sees the live request (store lanes get registered on
    // accept); afterwards it sees the latched request for load extraction.
    assign w_size    = (r_state == IDLE) ? mem_size_t'(req_size) : r_size;
    assign w_addr_lo = (r_state == IDLE) ? req_addr[1:0] : r_addr_lo;
    assign w_misal   = misaligned(mem_size_t'(req_size), req_addr[1:0]);
    assign w_timeout = r_cnt == 8'(TIMEOUT_CYCLES - 1);

    lsu_mem_port_lane_align u_align (
        .i_size    (w_size),
        .i_addr_lo (w_addr_lo),
        .i_sign    (r_sign),
        .i_wdata   (req_wdata),
        .i_rdata   (bus_rdata),
        .o_wstrb   (w_st_strb),
        .o_wdata   (w_st_data),
        .o_rdata   (w_ld_data)
    );

    assign req_ready = r_state == IDLE;
    assign done      = r_state == DONE;
    assign bus_valid = r_state == BUS_REQ;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign bus_we    = r_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wstrb = r_bus_wstrb;
    assign bus_wdata = r_bus_wdata;

    // Next state and the error flag that accompanies entry to DONE; a handshake wins over a same-cycle timeout.
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = req_valid ? (w_misal ? DONE : BUS_REQ) : IDLE;
                w_err  = req_valid & w_misal;
            end
            BUS_REQ: begin
                w_next = bus_ready ? (r_we ? DONE : BUS_RESP) : (w_timeout ? DONE : BUS_REQ);
                w_err  = ~bus_ready & w_timeout;
            end
            BUS_RESP: begin
                w_next = (bus_rvalid | w_timeout) ? DONE : BUS_RESP;
                w_err  = ~bus_rvalid & w_timeout;
            end
            default: w_next = IDLE;
        endcase
    end

    // State, wait counter (cleared whenever a wait state is entered), request latches and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_sign      <= 1'b0;
            r_size      <= MEM_BYTE;
            r_addr_lo   <= 2'b00;
            r_rdata     <= '0;
            r_bus_addr  <= '0;
            r_bus_wstrb <= 4'b0000;
            r_bus_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err;
            r_cnt   <= (w_next == r_state && (r_state == BUS_REQ || r_state == BUS_RESP)) ? r_cnt + 8'd1 : 8'd0;
            if (r_state == IDLE && req_valid) begin
                r_we        <= req_we;
                r_sign      <= req_sign;
                r_size      <= mem_size_t'(req_size);
                r_addr_lo   <= req_addr[1:0];
                r_bus_addr  <= {req_addr[DATA_WIDTH-1:2], 2'b00};
                r_bus_wstrb <= w_st_strb;
                r_bus_wdata <= w_st_data;
            end
            if (r_state == BUS_RESP && bus_rvalid) r_rdata <= w_ld_data;
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: randomized and directed checks of lsu_mem_port against a byte-lane reference model
module tb_lsu_mem_port;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_we, req_sign, req_ready, done, err;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [3:0]  bus_wstrb;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rdata;

    int          ob_lat, ob_wait;
    logic        ob_err, ob_bus_seen, ob_stable, ob_we, ob_after_done, ob_bv_at_done;
    logic [31:0] ob_rdata, ob_addr, ob_wdata;
    logic [3:0]  ob_wstrb;

    always #5 clk = ~clk;

    lsu_mem_port #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .done(done), .err(err), .rdata(rdata), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr);
        int n = nbytes(size);
        int base = int'(addr[1:0]);
        logic [3:0] s = '0;
        for (int b = 0; b < 4; b++) s[b] = (b >= base) && (b < base + n);
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        int n = nbytes(size);
        logic [31:0] o = '0;
        for (int b = 0; b < 4; b++) o[8*b +: 8] = wd[8*(b % n) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic sign,
                                           input logic [31:0] addr, input logic [31:0] mem);
        int n = nbytes(size);
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
        logic [31:0] v = (mem >> (8*int'(addr[1:0]))) & mask;
        if (sign && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Drives one access and plays the memory: ready after d1 bus_valid cycles, rvalid d2 cycles after the handshake.
    task automatic run_access(input logic we, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mem,
                              input int d1, input int d2, input logic noise);
        int k = 0;
        int nb = 0;
        int h = -1;
        req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        ob_wait = 0;
        while (!req_ready && ob_wait < 20) begin
            @(posedge clk); #1;
            ob_wait++;
        end
        ob_lat = -1; ob_bus_seen = 1'b0; ob_stable = 1'b1;
        while (ob_lat < 0 && k < 60) begin
            @(posedge clk); #1;
            k++;
            req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
            if (done) begin
                ob_lat = k; ob_err = err; ob_rdata = rdata; ob_bv_at_done = bus_valid;
            end else begin
                if (bus_valid) begin
                    if (!ob_bus_seen) begin
                        ob_addr = bus_addr; ob_wstrb = bus_wstrb; ob_wdata = bus_wdata; ob_we = bus_we;
                    end else if ({bus_addr, bus_wstrb, bus_wdata, bus_we} != {ob_addr, ob_wstrb, ob_wdata, ob_we}) begin
                        ob_stable = 1'b0;
                    end
                    ob_bus_seen = 1'b1;
                    nb++;
                    if (nb - 1 == d1) begin
                        bus_ready = 1'b1; h = k;
                    end else if (noise) begin
                        bus_rvalid = 1'b1;
                    end
                end
                if (h >= 0 && k == h + d2) begin
                    bus_rvalid = 1'b1; bus_rdata = mem;
                end
            end
        end
        @(posedge clk); #1;
        ob_after_done = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++; if ({done, err, bus_valid, bus_we} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {done, err, bus_valid, bus_we}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if ({bus_addr, bus_wdata, bus_wstrb} !== 68'h0) begin errors++; $display("FAIL reset_bus got %h/%h/%h want 0", bus_addr, bus_wdata, bus_wstrb); end
        rst = 1'b0;
        exp_rdata = 32'h0;
    endtask

    task automatic test_store();
        run_access(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0);
        checks++; if (ob_lat !== 2 || ob_err !== 1'b0) begin errors++; $display("FAIL sw_latency got %0d err %b want 2 err 0", ob_lat, ob_err); end
        checks++; if (ob_addr !== 32'h100 || ob_wstrb !== 4'b1111 || ob_we !== 1'b1) begin errors++; $display("FAIL sw_bus got %h %b %b want 100 1111 1", ob_addr, ob_wstrb, ob_we); end
        checks++; if (ob_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", ob_wdata); end
        checks++; if (ob_after_done !== 1'b0) begin errors++; $display("FAIL sw_done_pulse got %b want 0", ob_after_done); end
        run_access(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0, 1, 1'b0);
        checks++; if (ob_addr !== 32'h100 || ob_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_bus got %h %b want 100 1000", ob_addr, ob_wstrb); end
        checks++; if (ob_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", ob_wdata); end
        checks++; if (ob_rdata !== exp_rdata) begin errors++; $display("FAIL sb_rdata_hold got %h want %h", ob_rdata, exp_rdata); end
    endtask

    task automatic test_load();
        run_access(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 32'h1280FF00, 0, 1, 1'b0);
        checks++; if (ob_lat !== 3 || ob_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %0d %h want 3 ffffff80", ob_lat, ob_rdata); end
        run_access(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h1280FF00, 0, 1, 1'b0);
        checks++; if (ob_rdata !== 32'h00000080 || ob_we !== 1'b0) begin errors++; $display("FAIL lbu got %h we %b want 00000080 we 0", ob_rdata, ob_we); end
        exp_rdata = 32'h00000080;
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1, 1'b0);
        checks++; if (ob_lat !== 1 || ob_err !== 1'b1) begin errors++; $display("FAIL lh_misaligned got %0d err %b want 1 err 1", ob_lat, ob_err); end
        checks++; if (ob_bus_seen !== 1'b0) begin errors++; $display("FAIL lh_no_bus got %b want 0", ob_bus_seen); end
        checks++; if (ob_rdata !== exp_rdata) begin errors++; $display("FAIL lh_rdata_hold got %h want %h", ob_rdata, exp_rdata); end
    endtask

    task automatic test_stall();
        logic [31:0] m = $urandom;
        run_access(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, m, 3, 2, 1'b1);
        exp_rdata = m;
        checks++; if (ob_lat !== 7 || ob_err !== 1'b0) begin errors++; $display("FAIL lw_stall_latency got %0d err %b want 7 err 0", ob_lat, ob_err); end
        checks++; if (ob_stable !== 1'b1) begin errors++; $display("FAIL lw_stall_stable got %b want 1", ob_stable); end
        checks++; if (ob_rdata !== exp_rdata) begin errors++; $display("FAIL lw_stall_rdata got %h want %h", ob_rdata, exp_rdata); end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 2'd2, 1'b0, 32'h300, 32'h12345678, 32'h0, 99, 1, 1'b0);
        checks++; if (ob_lat !== 1 + TO || ob_err !== 1'b1) begin errors++; $display("FAIL req_timeout got %0d err %b want %0d err 1", ob_lat, ob_err, 1 + TO); end
        checks++; if (ob_bv_at_done !== 1'b0) begin errors++; $display("FAIL req_timeout_valid got %b want 0", ob_bv_at_done); end
        run_access(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'hCAFEF00D, 0, 99, 1'b0);
        checks++; if (ob_lat !== 2 + TO || ob_err !== 1'b1) begin errors++; $display("FAIL resp_timeout got %0d err %b want %0d err 1", ob_lat, ob_err, 2 + TO); end
        checks++; if (ob_rdata !== exp_rdata) begin errors++; $display("FAIL resp_timeout_rdata got %h want %h", ob_rdata, exp_rdata); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 2'd1, 1'b0, 32'h402, 32'h0000BEEF, 32'h0, 0, 1, 1'b0);
        run_access(1'b1, 2'd1, 1'b0, 32'h406, 32'h00001234, 32'h0, 0, 1, 1'b0);
        checks++; if (ob_wait !== 0 || ob_lat !== 2) begin errors++; $display("FAIL back_to_back got wait %0d lat %0d want 0 2", ob_wait, ob_lat); end
        checks++; if (ob_wstrb !== 4'b1100 || ob_wdata !== 32'h12341234) begin errors++; $display("FAIL b2b_half got %b %h want 1100 12341234", ob_wstrb, ob_wdata); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL mid_bus_valid got %b want 1", bus_valid); end
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({bus_valid, done, req_ready} !== 3'b001) begin errors++; $display("FAIL mid_reset got %b want 001", {bus_valid, done, req_ready}); end
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        repeat (6) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL mid_no_done got done %b rdata %h want 0 0", seen, rdata); end
        exp_rdata = 32'h0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic we = 1'($urandom);
            logic [1:0] sz = 2'($urandom);
            logic sg = 1'($urandom);
            logic [31:0] a = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] m = $urandom;
            int d1 = $urandom_range(0, 5);
            int d2 = $urandom_range(1, 6);
            int n = nbytes(sz);
            logic mis = (int'(a[1:0]) % n) != 0;
            int el;
            logic ee = 1'b0;
            if (mis) begin el = 1; ee = 1'b1; end
            else if (d1 >= TO) begin el = 1 + TO; ee = 1'b1; end
            else if (we) el = 2 + d1;
            else if (d2 - 1 >= TO) begin el = 2 + d1 + TO; ee = 1'b1; end
            else begin el = 2 + d1 + d2; exp_rdata = m_load(sz, sg, a, m); end
            run_access(we, sz, sg, a, wd, m, d1, d2, 1'($urandom));
            checks++; if (ob_lat !== el || ob_err !== ee) begin errors++; $display("FAIL rnd%0d_timing got %0d err %b want %0d err %b", i, ob_lat, ob_err, el, ee); end
            checks++; if (ob_rdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", i, ob_rdata, exp_rdata); end
            checks++; if (ob_bus_seen !== !mis) begin errors++; $display("FAIL rnd%0d_bus_seen got %b want %b", i, ob_bus_seen, !mis); end
            if (!mis) begin
                checks++; if (ob_addr !== {a[31:2], 2'b00} || ob_we !== we || ob_stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_bus got %h we %b stable %b want %h we %b stable 1", i, ob_addr, ob_we, ob_stable, {a[31:2], 2'b00}, we); end
                if (we) begin
                    checks++; if (ob_wstrb !== m_strb(sz, a) || ob_wdata !== m_wdata(sz, wd)) begin errors++; $display("FAIL rnd%0d_lanes got %b %h want %b %h", i, ob_wstrb, ob_wdata, m_strb(sz, a), m_wdata(sz, wd)); end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_store();
        test_load();
        test_misaligned();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
